// File: rtl/pipe_reg_mem_wb_skid_pkg.sv
// Shared pipeline definitions: skid-buffer state encoding and default
// MEM->WB payload widths used by the stage registers.
package pipe_reg_mem_wb_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skidState_e;

    localparam int DATA_W_DEFAULT = 32;
    localparam int DIR_W_DEFAULT  = 32;

    // Occupancy is reported as a beat count rather than as the raw encoding.
    function automatic logic [1:0] stateCount(input skidState_e state);
        logic [1:0] count;
        count = 2'd0;
        case (state)
            ST_EMPTY: count = 2'd0;
            ST_ONE:   count = 2'd1;
            ST_FULL:  count = 2'd2;
            default:  count = 2'd0;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer with valid/ready on both sides and a
// synchronous flush; ready depends only on registered state.
module pipe_skid_buf
    import pipe_reg_mem_wb_skid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_flush,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    skidState_e   state_q;
    logic [W-1:0] outData_q;
    logic [W-1:0] skidData_q;
    logic         inFire;
    logic         outFire;

    assign o_valid = (state_q != ST_EMPTY);
    assign o_ready = (state_q != ST_FULL);
    assign o_data  = outData_q;
    assign o_count = stateCount(state_q);
    assign inFire  = i_valid & o_ready;
    assign outFire = o_valid & i_ready;

    // Flush only resets occupancy; stale payload is hidden behind o_valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            outData_q  <= '0;
            skidData_q <= '0;
        end else if (i_flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (inFire) begin
                        state_q   <= ST_ONE;
                        outData_q <= i_data;
                    end
                end
                ST_ONE: begin
                    if (inFire && outFire) begin
                        outData_q <= i_data;
                    end else if (inFire) begin
                        state_q    <= ST_FULL;
                        skidData_q <= i_data;
                    end else if (outFire) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (outFire) begin
                        state_q   <= ST_ONE;
                        outData_q <= skidData_q;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/pipe_reg_mem_wb_skid.sv
// MEM->WB pipeline register built on the shared skid buffer; write-enable
// can be gated by valid so a bubble never writes the register file.
module pipe_reg_mem_wb_skid
    import pipe_reg_mem_wb_skid_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int DIR_W   = DIR_W_DEFAULT,
    parameter int GATE_WE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [DIR_W-1:0]  i_wb_dir,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_we,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [DIR_W-1:0]  o_wb_dir,
    output logic [1:0]        o_count
);

    localparam int W = 1 + DATA_W + DIR_W;

    logic [W-1:0] inPayload;
    logic [W-1:0] outPayload;
    logic         storedWe;

    assign inPayload = {i_we, i_wb_data, i_wb_dir};

    pipe_skid_buf #(
        .W (W)
    ) skidBuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (inPayload),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (outPayload),
        .o_count (o_count)
    );

    assign {storedWe, o_wb_data, o_wb_dir} = outPayload;
    assign o_we = (GATE_WE != 0) ? (storedWe & o_valid) : storedWe;

endmodule

// File: tb/tb_pipe_reg_mem_wb_skid.sv
// Randomized bench for the MEM->WB skid register, checked against a queue
// model of the beats held; a second instance covers the ungated o_we build.
module tb_pipe_reg_mem_wb_skid;

    localparam int DATA_W = 32;
    localparam int DIR_W  = 32;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] data;
        logic [DIR_W-1:0]  dir;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              iValid;
    logic              iWe;
    logic [DATA_W-1:0] iWbData;
    logic [DIR_W-1:0]  iWbDir;
    logic              iFlush;
    logic              iReady;

    logic              oReady, oValid, oWe;
    logic [DATA_W-1:0] oWbData;
    logic [DIR_W-1:0]  oWbDir;
    logic [1:0]        oCount;

    logic              rawReady, rawValid, rawWe;
    logic [DATA_W-1:0] rawWbData;
    logic [DIR_W-1:0]  rawWbDir;
    logic [1:0]        rawCount;

    beat_t modelQ[$];
    logic  modelLastWe;
    int    checkCount = 0;
    int    passCount  = 0;

    always #5 clk = ~clk;

    pipe_reg_mem_wb_skid #(.DATA_W(DATA_W), .DIR_W(DIR_W), .GATE_WE(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(iValid), .o_ready(oReady), .i_we(iWe),
        .i_wb_data(iWbData), .i_wb_dir(iWbDir), .i_flush(iFlush), .o_valid(oValid),
        .i_ready(iReady), .o_we(oWe), .o_wb_data(oWbData), .o_wb_dir(oWbDir),
        .o_count(oCount)
    );

    pipe_reg_mem_wb_skid #(.DATA_W(DATA_W), .DIR_W(DIR_W), .GATE_WE(0)) dutRaw (
        .clk(clk), .rst_n(rst_n), .i_valid(iValid), .o_ready(rawReady), .i_we(iWe),
        .i_wb_data(iWbData), .i_wb_dir(iWbDir), .i_flush(iFlush), .o_valid(rawValid),
        .i_ready(iReady), .o_we(rawWe), .o_wb_data(rawWbData), .o_wb_dir(rawWbDir),
        .o_count(rawCount)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    endtask

    // Compare both instances against the queue: the head of the queue is what WB sees.
    task automatic checkAll();
        logic  expValid;
        beat_t head;
        expValid = (modelQ.size() != 0);
        head     = expValid ? modelQ[0] : '0;
        checkOutput("valid", 64'(oValid), 64'(expValid));
        checkOutput("ready", 64'(oReady), 64'(modelQ.size() < 2));
        checkOutput("count", 64'(oCount), 64'(modelQ.size()));
        checkOutput("weGated", 64'(oWe), 64'(expValid && head.we));
        checkOutput("readyWhileFull", 64'(oReady && (oCount == 2'd2)), 64'd0);
        checkOutput("rawValid", 64'(rawValid), 64'(expValid));
        checkOutput("rawWe", 64'(rawWe), 64'(expValid ? head.we : modelLastWe));
        if (expValid) begin
            checkOutput("data", 64'(oWbData), 64'(head.data));
            checkOutput("dir", 64'(oWbDir), 64'(head.dir));
            checkOutput("rawData", 64'(rawWbData), 64'(head.data));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we,
                                 input logic [DATA_W-1:0] data,
                                 input logic [DIR_W-1:0] dir,
                                 input logic flush, input logic rdy);
        logic  inFire, outFire;
        beat_t beat;
        iValid  = v;
        iWe     = we;
        iWbData = data;
        iWbDir  = dir;
        iFlush  = flush;
        iReady  = rdy;
        beat    = '{we: we, data: data, dir: dir};
        inFire  = v && (modelQ.size() < 2);
        outFire = rdy && (modelQ.size() > 0);
        @(posedge clk);
        if (flush) begin
            modelQ.delete();
        end else begin
            if (outFire) void'(modelQ.pop_front());
            if (inFire) modelQ.push_back(beat);
        end
        if (modelQ.size() != 0) modelLastWe = modelQ[0].we;
        #1;
        checkAll();
    endtask

    initial begin
        rst_n = 1'b0;
        iValid = 1'b0; iWe = 1'b0; iWbData = '0; iWbDir = '0;
        iFlush = 1'b0; iReady = 1'b0;
        modelLastWe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        checkOutput("resetData", 64'(oWbData), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] streaming");
        applyStimulus(1'b1, 1'b1, 32'h1, 32'h10, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h2, 32'h11, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h3, 32'h12, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 1'b1, 32'hA, 32'h5, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'hB, 32'h6, 1'b0, 1'b0);
        checkOutput("bpHoldA", 64'(oWbData), 64'hA);
        applyStimulus(1'b1, 1'b1, 32'hD, 32'h7, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("bpThenB", 64'(oWbData), 64'hB);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("[TB] flush");
        applyStimulus(1'b1, 1'b1, 32'hA, 32'h5, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hB, 32'h6, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hC, 32'h8, 1'b1, 1'b0);
        checkOutput("flushWe", 64'(oWe), 64'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("[TB] we gating");
        applyStimulus(1'b1, 1'b1, 32'h55, 32'h3, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("bubbleWeGated", 64'(oWe), 64'd0);
        checkOutput("bubbleWeRaw", 64'(rawWe), 64'd1);

        $display("[TB] async reset mid-cycle");
        applyStimulus(1'b1, 1'b1, 32'h77, 32'h9, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        modelQ.delete();
        modelLastWe = 1'b0;
        checkAll();
        checkOutput("asyncData", 64'(oWbData), 64'd0);
        checkOutput("asyncDir", 64'(oWbDir), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] random");
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 70), 1'($urandom()),
                          32'($urandom()), 32'($urandom()),
                          ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 60));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
